// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - bin, one borrow cell, WIDTH run cycles.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             br;
  logic [CW-1:0]    count;
  logic             d;
  logic             b_next;

`ifdef SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
`endif

  assign d      = ra[0] ^ rb[0] ^ br;
  assign b_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      br        <= 1'b0;
      count     <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra       <= a;
            rb       <= b;
            br       <= bin;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef SUB_OVERFLOW_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          // LSB first: each result bit enters at the top of diff
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          br    <= b_next;
          diff  <= {d, diff[WIDTH-1:1]};
          count <= count + CW'(1);
          if (count == LAST) begin
            bout      <= b_next;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SUB_OVERFLOW_EN
            ovf       <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
